// File: rtl/synth_pkg.sv
// ============================================================================
// Module      : synth_pkg
// Description : Shared types and constants for the synth audio path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package synth_pkg;

    localparam int AUDIO_WIDTH      = 24;
    localparam int LEVEL_WIDTH      = 16;
    localparam int TICK_CYCLES_44K1 = 2268;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

endpackage

`default_nettype wire

// File: rtl/env_tick_gen.sv
// ============================================================================
// Module      : env_tick_gen
// Description : Free-running counter emitting a 1-cycle envelope tick strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module env_tick_gen #(
    parameter int TICK_CYCLES = 2268
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == C_LAST);
    assign o_tick = w_last;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/adsr_envelope.sv
// ============================================================================
// Module      : adsr_envelope
// Description : ADSR amplitude envelope with 2-stage signed sample multiply.
//               Optional macro ENV_VELOCITY_EN adds velocity-scaled peak level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adsr_envelope #(
    parameter int AUDIO_WIDTH = synth_pkg::AUDIO_WIDTH,
    parameter int LEVEL_WIDTH = synth_pkg::LEVEL_WIDTH,
    parameter int TICK_CYCLES = synth_pkg::TICK_CYCLES_44K1
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   gate_in,
`ifdef ENV_VELOCITY_EN
    input  logic [6:0]             velocity_in,
`endif
    input  logic [AUDIO_WIDTH-1:0] sample_data_in,
    input  logic [LEVEL_WIDTH-1:0] attack_rate_in,
    input  logic [LEVEL_WIDTH-1:0] decay_rate_in,
    input  logic [LEVEL_WIDTH-1:0] sustain_level_in,
    input  logic [LEVEL_WIDTH-1:0] release_rate_in,
    output logic [AUDIO_WIDTH-1:0] sample_data_out,
    output logic [LEVEL_WIDTH-1:0] env_level_out,
    output logic                   active_out
);

    import synth_pkg::*;

    env_state_t             r_state, w_state_nxt;
    logic [LEVEL_WIDTH-1:0] r_level, w_level_nxt;
    logic                   r_gate;
    logic                   w_tick, w_rise, w_fall;
    logic [LEVEL_WIDTH-1:0] w_peak, w_target;
    logic [LEVEL_WIDTH:0]   w_sum;
    logic [LEVEL_WIDTH-1:0] w_dec_diff, w_rel_diff;

    env_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick (
        .i_clk  (clk_in),
        .i_rst  (rst_in),
        .o_tick (w_tick)
    );

    assign w_rise = gate_in & ~r_gate;
    assign w_fall = ~gate_in & r_gate;

`ifdef ENV_VELOCITY_EN
    logic [6:0] r_velocity;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_velocity <= '0;
        end else if (w_rise) begin
            r_velocity <= velocity_in;
        end
    end

    // Replicating the 7-bit velocity spans the full scale: 127 maps to 0xFFFF.
    assign w_peak   = {r_velocity, r_velocity, r_velocity[6:5]};
    assign w_target = (sustain_level_in < w_peak) ? sustain_level_in : w_peak;
`else
    assign w_peak   = '1;
    assign w_target = sustain_level_in;
`endif

    assign w_sum      = {1'b0, r_level} + {1'b0, attack_rate_in};
    assign w_dec_diff = r_level - decay_rate_in;
    assign w_rel_diff = r_level - release_rate_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_level <= '0;
            r_gate  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_gate  <= gate_in;
        end
    end

    // Gate edges take priority over a coincident tick; no level update then.
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        case (r_state)
            IDLE: begin
                w_level_nxt = '0;
                if (w_rise) w_state_nxt = ATTACK;
            end
            ATTACK: begin
                if (w_fall) begin
                    w_state_nxt = RELEASE;
                end else if (w_tick) begin
                    if (w_sum >= {1'b0, w_peak}) begin
                        w_level_nxt = w_peak;
                        w_state_nxt = DECAY;
                    end else begin
                        w_level_nxt = w_sum[LEVEL_WIDTH-1:0];
                    end
                end
            end
            DECAY: begin
                if (w_fall) begin
                    w_state_nxt = RELEASE;
                end else if (w_tick) begin
                    if ((r_level < decay_rate_in) || (w_dec_diff <= w_target)) begin
                        w_level_nxt = w_target;
                        w_state_nxt = SUSTAIN;
                    end else begin
                        w_level_nxt = w_dec_diff;
                    end
                end
            end
            SUSTAIN: begin
                if (w_fall) begin
                    w_state_nxt = RELEASE;
                end else if (w_tick) begin
                    w_level_nxt = w_target;
                end
            end
            RELEASE: begin
                if (w_rise) begin
                    w_state_nxt = ATTACK;
                end else if (w_tick) begin
                    if (r_level <= release_rate_in) begin
                        w_level_nxt = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_level_nxt = w_rel_diff;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_level_nxt = '0;
            end
        endcase
    end

    logic signed [AUDIO_WIDTH-1:0]         r_s1_sample;
    logic        [LEVEL_WIDTH-1:0]         r_s1_level;
    logic signed [AUDIO_WIDTH+LEVEL_WIDTH:0] w_product, w_scaled;
    logic        [AUDIO_WIDTH-1:0]         r_out;

    // Level is zero-extended so it multiplies as a non-negative signed value.
    assign w_product = r_s1_sample * $signed({1'b0, r_s1_level});
    assign w_scaled  = w_product >>> LEVEL_WIDTH;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_s1_sample <= '0;
            r_s1_level  <= '0;
            r_out       <= '0;
        end else begin
            r_s1_sample <= sample_data_in;
            r_s1_level  <= r_level;
            r_out       <= w_scaled[AUDIO_WIDTH-1:0];
        end
    end

    assign sample_data_out = r_out;
    assign env_level_out   = r_level;
    assign active_out      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_adsr_envelope.sv
// ============================================================================
// Module      : tb_adsr_envelope
// Description : Directed self-checking bench for adsr_envelope (4-cycle tick).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adsr_envelope;

    import synth_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        gate_in;
    logic [23:0] sample_data_in;
    logic [15:0] attack_rate_in, decay_rate_in, sustain_level_in, release_rate_in;
    logic [23:0] sample_data_out;
    logic [15:0] env_level_out;
    logic        active_out;
`ifdef ENV_VELOCITY_EN
    logic [6:0]  velocity_in = 7'd127;
`endif

    int checks = 0;
    int errors = 0;

    adsr_envelope #(
        .AUDIO_WIDTH (24),
        .LEVEL_WIDTH (16),
        .TICK_CYCLES (4)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .gate_in          (gate_in),
`ifdef ENV_VELOCITY_EN
        .velocity_in      (velocity_in),
`endif
        .sample_data_in   (sample_data_in),
        .attack_rate_in   (attack_rate_in),
        .decay_rate_in    (decay_rate_in),
        .sustain_level_in (sustain_level_in),
        .release_rate_in  (release_rate_in),
        .sample_data_out  (sample_data_out),
        .env_level_out    (env_level_out),
        .active_out       (active_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic wait_level_change(output bit ok);
        logic [15:0] prev;
        prev = env_level_out;
        ok   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_in);
            #1;
            if (env_level_out !== prev) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_in           = 1'b1;
        gate_in          = 1'b0;
        sample_data_in   = '0;
        attack_rate_in   = 16'h4000;
        decay_rate_in    = 16'h1000;
        sustain_level_in = 16'h8000;
        release_rate_in  = 16'h3000;
        step(3);
        checks++;
        if (env_level_out !== 16'h0000) begin
            errors++; $display("FAIL reset_level: got %h expected 0000", env_level_out);
        end
        checks++;
        if (active_out !== 1'b0) begin
            errors++; $display("FAIL reset_active: got %b expected 0", active_out);
        end
        checks++;
        if (sample_data_out !== 24'h000000) begin
            errors++; $display("FAIL reset_sample: got %h expected 000000", sample_data_out);
        end
        rst_in = 1'b0;
        step(2);
    endtask

    task automatic test_attack();
        logic [15:0] exp_lv [4] = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
        bit ok;
        gate_in = 1'b1;
        step(1);
        checks++;
        if (dut.r_state !== ATTACK) begin
            errors++; $display("FAIL attack_enter: got state %0d expected %0d", dut.r_state, ATTACK);
        end
        for (int k = 0; k < 4; k++) begin
            wait_level_change(ok);
            checks++;
            if (!ok || env_level_out !== exp_lv[k]) begin
                errors++; $display("FAIL attack_step%0d: got %h expected %h", k, env_level_out, exp_lv[k]);
            end
        end
        checks++;
        if (dut.r_state !== DECAY) begin
            errors++; $display("FAIL attack_to_decay: got state %0d expected %0d", dut.r_state, DECAY);
        end
    endtask

    task automatic test_decay();
        logic [15:0] expv;
        bit ok;
        for (int k = 0; k < 8; k++) begin
            expv = (k == 7) ? 16'h8000 : 16'hEFFF - 16'(k * 16'h1000);
            wait_level_change(ok);
            checks++;
            if (!ok || env_level_out !== expv) begin
                errors++; $display("FAIL decay_step%0d: got %h expected %h", k, env_level_out, expv);
            end
        end
        checks++;
        if (dut.r_state !== SUSTAIN) begin
            errors++; $display("FAIL decay_to_sustain: got state %0d expected %0d", dut.r_state, SUSTAIN);
        end
    endtask

    task automatic test_multiply();
        sample_data_in = 24'h400000;
        step(1);
        checks++;
        if (sample_data_out !== 24'h000000) begin
            errors++; $display("FAIL mul_latency1: got %h expected 000000", sample_data_out);
        end
        step(1);
        checks++;
        if (sample_data_out !== 24'h200000) begin
            errors++; $display("FAIL mul_pos: got %h expected 200000", sample_data_out);
        end
        sample_data_in = 24'hC00000;
        step(2);
        checks++;
        if (sample_data_out !== 24'hE00000) begin
            errors++; $display("FAIL mul_neg: got %h expected E00000", sample_data_out);
        end
        checks++;
        if (env_level_out !== 16'h8000) begin
            errors++; $display("FAIL sustain_hold: got %h expected 8000", env_level_out);
        end
    endtask

    task automatic test_release();
        logic [15:0] exp_lv [3] = '{16'h5000, 16'h2000, 16'h0000};
        bit ok;
        gate_in = 1'b0;
        step(1);
        checks++;
        if (dut.r_state !== RELEASE) begin
            errors++; $display("FAIL release_enter: got state %0d expected %0d", dut.r_state, RELEASE);
        end
        for (int k = 0; k < 3; k++) begin
            wait_level_change(ok);
            checks++;
            if (!ok || env_level_out !== exp_lv[k]) begin
                errors++; $display("FAIL release_step%0d: got %h expected %h", k, env_level_out, exp_lv[k]);
            end
            checks++;
            if (active_out !== (k != 2)) begin
                errors++; $display("FAIL release_active%0d: got %b expected %b", k, active_out, (k != 2));
            end
        end
        step(2);
        checks++;
        if (sample_data_out !== 24'h000000) begin
            errors++; $display("FAIL mul_zero_level: got %h expected 000000", sample_data_out);
        end
    endtask

    task automatic test_retrigger();
        bit ok;
        decay_rate_in = 16'hFFFF;
        gate_in       = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (dut.r_state == SUSTAIN) break;
        end
        gate_in = 1'b0;
        ok      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (env_level_out == 16'h5000) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL retrig_setup: got %h expected 5000", env_level_out);
        end
        gate_in = 1'b1;
        step(1);
        checks++;
        if (dut.r_state !== ATTACK || env_level_out !== 16'h5000) begin
            errors++; $display("FAIL retrig_enter: got state %0d level %h expected state %0d level 5000",
                               dut.r_state, env_level_out, ATTACK);
        end
        wait_level_change(ok);
        checks++;
        if (!ok || env_level_out !== 16'h9000) begin
            errors++; $display("FAIL retrig_step: got %h expected 9000", env_level_out);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        step(2);
        checks++;
        if (sample_data_out === 24'h000000 || active_out !== 1'b1) begin
            errors++; $display("FAIL pre_reset_activity: got sample %h active %b expected nonzero and 1",
                               sample_data_out, active_out);
        end
        #2 rst_in = 1'b1;
        #1;
        checks++;
        if (env_level_out !== 16'h0000 || active_out !== 1'b0 || sample_data_out !== 24'h000000) begin
            errors++; $display("FAIL async_reset: got level %h active %b sample %h expected all 0",
                               env_level_out, active_out, sample_data_out);
        end
        step(1);
        rst_in = 1'b0;
        step(1);
        checks++;
        if (dut.r_state !== ATTACK || env_level_out !== 16'h0000) begin
            errors++; $display("FAIL restart_enter: got state %0d level %h expected state %0d level 0000",
                               dut.r_state, env_level_out, ATTACK);
        end
        wait_level_change(ok);
        checks++;
        if (!ok || env_level_out !== 16'h4000) begin
            errors++; $display("FAIL restart_step: got %h expected 4000", env_level_out);
        end
    endtask

    initial begin
        test_reset();
        test_attack();
        test_decay();
        test_multiply();
        test_release();
        test_retrigger();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
